// File: rtl/wsync_rptr_level.sv
// Write-domain read-pointer synchronizer with Gray decode, registered fill level and almost-full.
// Optional sticky integrity checker enabled by defining WSYNC_RPTR_GRAY_CHK_EN.
module wsync_rptr_level #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2,   // >= 2
  parameter int AF_LEVEL    = 14   // 1 .. 2**ASIZE
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [ASIZE:0]   rptr,
  input  logic [ASIZE:0]   wptr,
  output logic [ASIZE:0]   wq2_rptr,
  output logic [ASIZE:0]   wq2_rbin,
  output logic [ASIZE:0]   wlevel,
  output logic             wafull,
  output logic             wgray_err
);

  localparam int            PW     = ASIZE + 1;
  localparam logic [ASIZE:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [ASIZE:0] DEPTH  = {1'b1, {ASIZE{1'b0}}};

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Plain flop chain: nothing combinational may sit between stages.
  logic [SYNC_STAGES-1:0][ASIZE:0] sync_q;
  logic [ASIZE:0]                  rlast;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rlast    = sync_q[SYNC_STAGES-1];
  assign wq2_rptr = rlast;

  // Stage A: decode both pointers to binary.
  logic [ASIZE:0] wq2_rbin_q, wq2_rbin_d;
  logic [ASIZE:0] wbin_q, wbin_d;

  assign wq2_rbin_d = gray2bin(rlast);
  assign wbin_d     = gray2bin(wptr);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq2_rbin_q <= '0;
      wbin_q     <= '0;
    end else begin
      wq2_rbin_q <= wq2_rbin_d;
      wbin_q     <= wbin_d;
    end
  end

  assign wq2_rbin = wq2_rbin_q;

  // Stage B: modulo-2^(ASIZE+1) difference absorbs pointer wrap.
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           wafull_q, wafull_d;

  assign wlevel_d = wbin_q - wq2_rbin_q;
  assign wafull_d = (wlevel_d >= AF_THR);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      wafull_q <= 1'b0;
    end else begin
      wlevel_q <= wlevel_d;
      wafull_q <= wafull_d;
    end
  end

  assign wlevel = wlevel_q;
  assign wafull = wafull_q;

`ifdef WSYNC_RPTR_GRAY_CHK_EN
  logic [ASIZE:0] rlast_prev_q;
  logic [ASIZE:0] rstep;
  logic           multi_bit, level_bad;
  logic           gray_err_q, gray_err_d;

  // Clearing the lowest set bit leaves something only if two or more bits toggled.
  assign rstep      = rlast ^ rlast_prev_q;
  assign multi_bit  = |(rstep & (rstep - PW'(1)));
  assign level_bad  = (wlevel_q > DEPTH);
  assign gray_err_d = gray_err_q | multi_bit | level_bad;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rlast_prev_q <= '0;
      gray_err_q   <= 1'b0;
    end else begin
      rlast_prev_q <= rlast;
      gray_err_q   <= gray_err_d;
    end
  end

  assign wgray_err = gray_err_q;
`else
  assign wgray_err = 1'b0;
`endif

endmodule

// File: tb/tb_wsync_rptr_level.sv
// Randomized + directed bench for wsync_rptr_level with a history-based reference model and scoreboard.
module tb_wsync_rptr_level;

  localparam int ASIZE = 4;
  localparam int SYNC  = 2;
  localparam int AF    = 14;
  localparam int DEPTH = 1 << ASIZE;
  localparam int MODV  = 2 * DEPTH;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [4:0] rptr = '0, wptr = '0;
  logic [4:0] wq2_rptr, wq2_rbin, wlevel;
  logic       wafull, wgray_err;

  wsync_rptr_level #(.ASIZE(ASIZE), .SYNC_STAGES(SYNC), .AF_LEVEL(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wptr(wptr),
    .wq2_rptr(wq2_rptr), .wq2_rbin(wq2_rbin), .wlevel(wlevel),
    .wafull(wafull), .wgray_err(wgray_err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int rq;
    int rbin;
    int lvl;
    int af;
    int err;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] rh[$], wh[$];   // input value presented before each edge since reset
  int         total = 0, bad = 0;
  int         sticky = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2i(input logic [4:0] g);
    int v = 0;
    for (int i = 0; i < 5; i++) v = v ^ (int'(g) >> i);
    return v;
  endfunction

  function automatic logic [4:0] i2g(input int b);
    int v = b % MODV;
    return 5'(v ^ (v >> 1));
  endfunction

  // k edges back; before reset release everything reads as zero.
  function automatic logic [4:0] hget(input logic [4:0] q[$], input int k);
    if (k >= q.size()) return 5'd0;
    return q[q.size()-1-k];
  endfunction

  function automatic int level_at(input int back);
    return ((g2i(hget(wh, 1 + back)) - g2i(hget(rh, SYNC + 1 + back))) % MODV + MODV) % MODV;
  endfunction

  function automatic int popc(input int v);
    int c = 0;
    for (int i = 0; i < 5; i++) c += (v >> i) & 1;
    return c;
  endfunction

  // Expected state right after the edge that just happened.
  task automatic push_exp();
    exp_t e;
    e.rq   = hget(rh, SYNC - 1);
    e.rbin = g2i(hget(rh, SYNC));
    e.lvl  = level_at(0);
    e.af   = (e.lvl >= AF) ? 1 : 0;
`ifdef WSYNC_RPTR_GRAY_CHK_EN
    if (popc(int'(hget(rh, SYNC) ^ hget(rh, SYNC + 1))) > 1 || level_at(1) > DEPTH) sticky = 1;
`endif
    e.err = sticky;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] w);
    rptr = r;
    wptr = w;
    rh.push_back(r);
    wh.push_back(w);
    @(posedge wclk);
    #1;
    push_exp();
  endtask

  // Asserted mid-cycle to exercise the asynchronous clear.
  task automatic do_reset();
    #2;
    wrst_n = 1'b0;
    #1;
    chk("rst_wq2_rptr", wq2_rptr, 0);
    chk("rst_wq2_rbin", wq2_rbin, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wafull", wafull, 0);
    chk("rst_wgray_err", wgray_err, 0);
    exp_q.delete();
    rh.delete();
    wh.delete();
    sticky = 0;
    repeat (2) @(posedge wclk);
    #2;
    wrst_n = 1'b1;
  endtask

  always @(negedge wclk) begin
    if (wrst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wq2_rptr", wq2_rptr, e.rq);
      chk("wq2_rbin", wq2_rbin, e.rbin);
      chk("wlevel", wlevel, e.lvl);
      chk("wafull", wafull, e.af);
      chk("wgray_err", wgray_err, e.err);
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb;
    repeat (2) @(posedge wclk);
    #2;
    wrst_n = 1'b1;

    // Reset mid-traffic with rptr parked at 5'b11011
    for (int i = 0; i < 4; i++) step(i2g(i), i2g(i + 3));
    rptr = 5'b11011;
    do_reset();
    for (int i = 0; i < 4; i++) step(5'b11011, 5'b11011);
    chk("post_rst_wq2_rptr", wq2_rptr, 27);

    // Fill ramp
    do_reset();
    for (int i = 0; i <= 10; i++) step(5'd0, i2g(i));
    repeat (3) step(5'd0, i2g(10));
    chk("ramp_end_level", wlevel, 10);

    // Almost-full threshold both sides
    repeat (3) step(5'd0, 5'b01001);
    chk("af14_level", wlevel, 14);
    chk("af14_flag", wafull, 1);
    repeat (3) step(5'd0, 5'b01011);
    chk("af13_flag", wafull, 0);

    // Wrap then drain (rptr jump is a multi-bit change, so reset afterwards)
    repeat (5) step(5'b00010, 5'b11011);
    chk("wrap_level", wlevel, 15);
    repeat (5) step(5'b11011, 5'b11011);
    chk("drain_level", wlevel, 0);

    // Full
    do_reset();
    repeat (5) step(5'd0, 5'b11000);
    chk("full_level", wlevel, 16);
    chk("full_flag", wafull, 1);

    // Illegal Gray jump, then legal single steps
    do_reset();
    repeat (3) step(5'd0, 5'd0);
    step(5'b00011, 5'b00011);
    for (int i = 2; i <= 5; i++) step(i2g(i), 5'b00111);
    repeat (3) step(i2g(5), 5'b00111);

    // Randomized legal FIFO traffic with an occasional mid-traffic reset
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      rb = 0;
      wb = 0;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 2) != 0 && wb - rb < DEPTH)
          wb += $urandom_range(1, (DEPTH - (wb - rb) > 3) ? 3 : DEPTH - (wb - rb));
        if ($urandom_range(0, 1) != 0 && rb < wb - SYNC) rb += 1;
        step(i2g(rb), i2g(wb));
      end
    end

    @(negedge wclk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wsync_rptr_level.md
# wsync_rptr_level

Write-domain companion to the write-pointer/full logic of the async FIFO. It brings the read-side Gray pointer into `wclk` through a multi-flop synchronizer and hands the synchronized Gray pointer to the full-flag logic. It also decodes both Gray pointers (read and write) back to binary and produces a registered write-side fill level and almost-full flag. An optional sticky integrity checker flags illegal Gray transitions and impossible levels.

## Interface
- `ASIZE`, 4, address width; FIFO depth is 2^ASIZE; pointers are ASIZE+1 bits
- `SYNC_STAGES`, 2, synchronizer depth; must be >= 2
- `AF_LEVEL`, 14, almost-full threshold; legal range 1..2^ASIZE

- `wclk`  in  1  write clock
- `wrst_n`  in  1  asynchronous active-low reset
- `rptr`  in  ASIZE+1  read pointer, Gray, from `rclk` domain
- `wptr`  in  ASIZE+1  write pointer, Gray, from write-pointer logic
- `wq2_rptr`  out  ASIZE+1  synchronized read Gray pointer, last sync stage
- `wq2_rbin`  out  ASIZE+1  synchronized read pointer, binary, registered
- `wlevel`  out  ASIZE+1  registered fill level, 0..2^ASIZE
- `wafull`  out  1  registered, high when level >= AF_LEVEL
- `wgray_err`  out  1  sticky integrity error (see Configuration)

## Operation
- Synchronizer: `SYNC_STAGES` flops on `rptr`. No logic between stages. `wq2_rptr` is the last stage output.
- Gray-to-binary decode: b[ASIZE] = g[ASIZE]; b[i] = b[i+1] ^ g[i]. Decoding is combinational on the last sync stage and on `wptr`.
- Stage A registers: `wq2_rbin` <= decode(last sync stage); `wbin_q` <= decode(`wptr`). `wbin_q` is internal.
- Stage B registers:
  - `wlevel` <= (`wbin_q` - `wq2_rbin`), computed modulo 2^(ASIZE+1).
  - `wafull` <= (same difference >= AF_LEVEL).
- Level arithmetic:
  - Unsigned, ASIZE+1 bits. Wrap-around of either pointer is handled by the modulo subtraction.
  - Legal results are 0..2^ASIZE.
  - The value is presented raw, with no saturation.
- Boundary conditions:
  - Empty: equal pointers give `wlevel` = 0.
  - Full: MSB differs and the rest are equal, giving `wlevel` = 2^ASIZE and `wafull` = 1.
  - Both pointers changing in the same cycle: each pointer propagates with its own latency; no special handling.
- Reset (async assert, mid-operation included): all sync flops, `wq2_rbin`, `wbin_q`, `wlevel`, `wafull`, and `wgray_err` clear to 0 immediately.
- Reset release: the block resumes sampling on the next `wclk` edge.

## Timing
- Changes are counted in `wclk` edges after the input is stable.
- `rptr` to outputs:
  - `wq2_rptr`: SYNC_STAGES edges.
  - `wq2_rbin`: SYNC_STAGES+1 edges.
  - `wlevel`/`wafull`: SYNC_STAGES+2 edges.
- `wptr` to `wlevel`/`wafull`: 2 edges.
- Every output is a flop output; there are no combinational input-to-output paths.
- Reset value of all outputs: 0.

## Configuration
- Macro: `WSYNC_RPTR_GRAY_CHK_EN`.
- Defined:
  - `wgray_err` sets when the last sync stage differs from its previous-cycle value in more than one bit.
  - `wgray_err` also sets when the stage-B difference exceeds 2^ASIZE.
  - It is sticky, set on the edge after detection, and clears only on `wrst_n`.
  - Detection has no effect on `wlevel` or `wafull`.
- Undefined: the checker logic is absent and `wgray_err` is tied to 0.

## Test plan
All scenarios use ASIZE=4, SYNC_STAGES=2, AF_LEVEL=14.
1. Reset: assert `wrst_n`=0 mid-traffic with `rptr`=5'b11011 -> all outputs 0 immediately. After release, `wq2_rptr`=5'b11011 two edges later.
2. Fill ramp: `rptr`=0; step `wptr` through Gray codes of binary 0..10, one per cycle -> `wlevel` tracks binary with a 2-edge lag, ends at 10; `wafull`=0 throughout.
3. Almost-full: `rptr`=0, `wptr`=5'b01001 (bin 14) -> two edges later `wlevel`=14, `wafull`=1. With `wptr`=5'b01011 (bin 13) -> `wlevel`=13, `wafull`=0.
4. Wrap and drain:
   - `wptr`=5'b11011 (bin 18), `rptr`=5'b00010 (bin 3) -> `wlevel`=15, `wafull`=1.
   - Then `rptr`=5'b11011 -> `wq2_rbin`=18 after 3 edges, `wlevel`=0 and `wafull`=0 after 4 edges.
5. Full: `wptr`=5'b11000 (bin 16), `rptr`=0 -> `wlevel`=16, `wafull`=1, `wgray_err`=0.
6. Checker (macro defined): `rptr` jumps from 0 to 5'b00011 in one cycle -> `wgray_err`=1 at edge 3 and stays 1 after `rptr` returns to legal steps, until reset. With the macro undefined, the same stimulus leaves `wgray_err`=0.
